seven_seg_scan_controller: RTL
==============================

Name: seven_seg_scan_controller

Overview:
- Time-multiplexes one shared combinational BCD-to-seven-segment decoder across NUM_DIGITS common-anode/cathode digit positions.
- Holds a double-buffered display value and sequences digit select with an anti-ghosting blank gap.
- Accepts new values through a valid/ready handshake and commits them only at frame boundaries, so a frame never shows torn data.
- Sits between the numeric source (counter/ALU) and the board's segment/digit pins.

Parameters:
- NUM_DIGITS, 4, number of digit positions scanned (>=2).
- DIV, 1000, clock cycles each digit is lit per scan slot (>=1).
- BLANK_CYCLES, 2, clock cycles all digits are off before each slot (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- load_valid  input  1  new display value offered.
- load_ready  output  1  controller can accept load_data.
- load_data  input  4*NUM_DIGITS  packed BCD; nibble i = digit i, where digit 0 is least significant.
- lzb_en  input  1  leading-zero blanking enable.
- bcd_out  output  4  nibble of the current digit, driven to the shared decoder.
- seg_in  input  7  decoder result {a..g} for bcd_out.
- seg_out  output  7  registered segment drive, active-high.
- an_out  output  NUM_DIGITS  registered digit enable, one-hot or zero.
- frame_done  output  1  one-cycle pulse at the frame boundary.

Behaviour:
- Registers:
  - active (display value), pending (value awaiting commit) and pending_valid.
  - idx (0..NUM_DIGITS-1), phase (BLANK/SHOW) and cnt.
- Reset (rst high at clk edge):
  - active=0, pending=0, pending_valid=0, idx=0, phase=BLANK, cnt=0.
  - seg_out=0, an_out=0, frame_done=0.
  - load_ready is 0 while rst is high.
- Handshake:
  - load_ready = ~pending_valid & ~rst (combinational).
  - Transfer occurs on a cycle with load_valid & load_ready: pending<=load_data, pending_valid<=1.
  - load_data is ignored when load_ready=0; the source must hold it until transfer.
- Phase FSM:
  - BLANK: cnt counts 0..BLANK_CYCLES-1. At cnt=BLANK_CYCLES-1, go to SHOW with cnt=0.
  - SHOW: cnt counts 0..DIV-1. At cnt=DIV-1, go to BLANK with cnt=0 and idx<=idx+1, wrapping NUM_DIGITS-1 to 0.
- Frame boundary: the last SHOW cycle of idx=NUM_DIGITS-1.
  - frame_done is high for exactly that cycle (combinational from state).
  - If pending_valid, then active<=pending and pending_valid<=0. The new value is first shown on digit 0 of the next frame.
  - A transfer and a commit in the same cycle cannot both happen, because load_ready=0 when pending_valid=1.
  - With pending_valid=0, a transfer on the boundary cycle is committed at the next boundary.
- Frame length is NUM_DIGITS*(BLANK_CYCLES+DIV) cycles.
- bcd_out = active[4*idx +: 4] (combinational). It changes when idx changes, at the start of BLANK, so the decoder settles during the gap. Values 10-15 pass through unmodified.
- Leading-zero blanking: digit i>0 is blanked when lzb_en=1 and nibbles NUM_DIGITS-1 down to i of active are all 0. Digit 0 is never blanked.
- Registered outputs, one cycle after the state they reflect:
  - an_out <= (phase==SHOW && !blanked(idx)) ? (1<<idx) : 0.
  - seg_out <= same condition ? seg_in : 7'b0.
  - an_out and seg_out are therefore never non-zero during the first cycle after any BLANK entry.
- Reset mid-frame: immediate return to reset state. Any pending value is discarded and scanning restarts at idx=0 in BLANK.
- lzb_en may change at any time and takes effect on the next registered output update.
- Invariant: popcount(an_out) <= 1 every cycle.

Test Plan (NUM_DIGITS=4, DIV=4, BLANK_CYCLES=2, so frame = 24 cycles):
- Reset, then run 48 cycles with no load:
  - load_ready=1.
  - frame_done pulses at cycles 23 and 47 after reset release.
  - an_out sequence per slot is 0,0 then 0001 for 4 cycles, then 0010, 0100, 1000 likewise.
  - seg_out equals the model decode of 0 during SHOW.
- Load 16'h1234 with the handshake mid-frame:
  - load_ready drops the next cycle and stays 0 until the boundary, then returns to 1.
  - The next frame shows bcd_out 4,3,2,1 on digits 0..3.
  - The current frame still shows 0.
- Hold load_valid with 16'hABCD while pending_valid=1:
  - No transfer occurs until load_ready rises after the commit.
  - 16'hABCD is displayed exactly one frame after 16'h1234.
- lzb_en=1 with 16'h0050:
  - Digits 3 and 2 have an_out=0 and seg_out=0 in their slots.
  - Digits 1 and 0 are lit.
  - With 16'h0000, only digit 0 lights.
- Assert rst for 1 cycle during SHOW of idx=2 with a pending value:
  - All outputs are 0 the next cycle and active=0.
  - Scanning restarts at digit 0 after BLANK_CYCLES+1 cycles.
- Every cycle, check popcount(an_out)<=1 and that seg_out=0 whenever an_out=0.

Source files
------------

// File: rtl/seven_seg_scan_controller.sv
// Multiplexed seven-segment scanner: double-buffered BCD value, frame-aligned commit,
// blank gap before every digit slot and optional leading-zero blanking.
module seven_seg_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int DIV          = 1000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic                    lzb_en,
   output logic [3:0]              bcd_out,
   input  logic [6:0]              seg_in,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_done
);

   localparam int CNT_MAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } phase_t;

   phase_t                    phase_reg, phase_next;
   logic [CNT_W-1:0]          cnt_reg, cnt_next;
   logic [IDX_W-1:0]          idx_reg, idx_next;
   logic [4*NUM_DIGITS-1:0]   active_reg, active_next;
   logic [4*NUM_DIGITS-1:0]   pending_reg, pending_next;
   logic                      pending_valid_reg, pending_valid_next;
   logic [NUM_DIGITS-1:0]     an_reg, an_next;
   logic [6:0]                seg_reg, seg_next;
   logic [NUM_DIGITS-1:0]     blanked;
   logic                      frame_end;
   logic                      lit;

   // A digit is blanked when it and every more significant nibble are zero.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
      if (gi == 0) begin : g_lsd
         assign blanked[gi] = 1'b0;
      end else begin : g_upper
         assign blanked[gi] = lzb_en & ~(|active_reg[4*NUM_DIGITS-1:4*gi]);
      end
   end

   assign load_ready = ~pending_valid_reg & ~rst;
   assign bcd_out    = active_reg[4*idx_reg +: 4];
   assign frame_done = frame_end;
   assign an_out     = an_reg;
   assign seg_out    = seg_reg;

   always_comb begin
      phase_next         = phase_reg;
      cnt_next           = cnt_reg;
      idx_next           = idx_reg;
      active_next        = active_reg;
      pending_next       = pending_reg;
      pending_valid_next = pending_valid_reg;
      frame_end          = 1'b0;

      case (phase_reg)
         BLANK: begin
            if (cnt_reg == BLANK_LAST) begin
               phase_next = SHOW;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         SHOW: begin
            if (cnt_reg == SHOW_LAST) begin
               phase_next = BLANK;
               cnt_next   = '0;
               if (idx_reg == IDX_LAST) begin
                  idx_next  = '0;
                  frame_end = 1'b1;
               end else begin
                  idx_next = idx_reg + IDX_W'(1);
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            phase_next = BLANK;
            cnt_next   = '0;
         end
      endcase

      // Transfer and commit are mutually exclusive since load_ready needs pending_valid low.
      if (load_valid && load_ready) begin
         pending_next       = load_data;
         pending_valid_next = 1'b1;
      end
      if (frame_end && pending_valid_reg) begin
         active_next        = pending_reg;
         pending_valid_next = 1'b0;
      end

      lit      = (phase_reg == SHOW) && !blanked[idx_reg];
      an_next  = lit ? (NUM_DIGITS'(1) << idx_reg) : '0;
      seg_next = lit ? seg_in : 7'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_reg         <= BLANK;
         cnt_reg           <= '0;
         idx_reg           <= '0;
         active_reg        <= '0;
         pending_reg       <= '0;
         pending_valid_reg <= 1'b0;
         an_reg            <= '0;
         seg_reg           <= 7'b0;
      end else begin
         phase_reg         <= phase_next;
         cnt_reg           <= cnt_next;
         idx_reg           <= idx_next;
         active_reg        <= active_next;
         pending_reg       <= pending_next;
         pending_valid_reg <= pending_valid_next;
         an_reg            <= an_next;
         seg_reg           <= seg_next;
      end
   end

endmodule
